tlbcode_responder: RTL and testbench
====================================

Name: tlbcode_responder

Overview:
- Responder end of the code-TLB request/response interface driven by the prefetch controller.
- Holds a small fully-associative cache of code-page translations. A hit returns the linear address, physical address and cache-disable attribute one cycle after the request is sampled.
- A miss forwards the request to the page walker, fills an entry from the walker's result, then responds.
- Sits between the prefetch controller and the shared page-walk/TLB unit.

Parameters:
- ENTRIES, 4, number of cached code translations; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- tlbcoderequest_do  in  1  request; initiator holds it and the address/su fields stable until tlbcode_do, or drops it on pipeline reset
- tlbcoderequest_address  in  32  linear fetch address
- tlbcoderequest_su  in  1  supervisor/user level of the request
- tlbcode_do  out  1  one-cycle response strobe
- tlbcode_linear  out  32  echoed linear address
- tlbcode_physical  out  32  translated physical address
- tlbcode_cache_disable  out  1  page cache-disable attribute
- tlbcode_fault  out  1  one-cycle pulse: the walker reported a fault for this request
- tlbflush  in  1  invalidate all entries
- walk_do  out  1  walk request, held until walk_done
- walk_address  out  32  linear address to walk
- walk_su  out  1  su level to walk with
- walk_done  in  1  walker completion strobe
- walk_physical  in  32  page base; bits [11:0] ignored
- walk_cache_disable  in  1  page cache-disable attribute
- walk_fault  in  1  qualifies walk_done as a fault

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; all valid bits 0; replacement pointer 0; flush_pending 0.
- Entry contents: valid, tag = linear[31:12], su, phys[31:12], cd.
- Hit condition: valid && tag == tlbcoderequest_address[31:12] && su == tlbcoderequest_su. At most one entry can hit.
- States: IDLE, RESPOND, WALK, FAULT.
- IDLE, with tlbcoderequest_do=1 and tlbflush=0:
  - On hit, register the response and go to RESPOND: tlbcode_linear = address; tlbcode_physical = {phys[31:12], address[11:0]}; tlbcode_cache_disable = cd.
  - On miss, go to WALK with walk_do=1, walk_address = request address, walk_su = request su.
- IDLE with tlbflush=1: clear all valid bits; suppress lookup that cycle.
- RESPOND: tlbcode_do=1 for exactly this cycle. The request is not re-sampled this cycle. Next state IDLE.
- WALK: walk_do stays 1 until the cycle walk_done=1 (inclusive).
  - walk_done && !walk_fault: write the entry at the pointer; pointer += 1, wrapping ENTRIES-1 -> 0. Then go to RESPOND with fields formed from walk data, or to IDLE if tlbcoderequest_do=0 that cycle (request dropped: fill still occurs, no response).
  - walk_done && walk_fault: no fill, pointer unchanged; tlbcode_fault=1 next cycle; go to FAULT.
- FAULT: tlbcode_fault is a one-cycle pulse on entry. Stay in FAULT until tlbcoderequest_do=0, then go to IDLE. This prevents a re-walk loop while the initiator holds the faulting request.
- tlbflush in WALK: clear valids, set flush_pending. At walk_done, with flush_pending set or tlbflush=1 that cycle: no fill, no response; go to IDLE; clear flush_pending. The initiator's held request then re-misses and walks again.
- tlbflush in RESPOND: the response completes; all valids clear.
- Latency: hit = response 1 cycle after the request is sampled; miss = 1 cycle after walk_done.
- tlbcode_* output fields hold their last value when tlbcode_do=0.

Test Plan:
- Reset, request addr 0x0040_1234 su=0 (cold) -> walk_do=1 with walk_address=0x0040_1234. walk_done with phys 0x1234_5000, cd=1 -> next cycle tlbcode_do=1, physical=0x1234_5234, linear=0x0040_1234, cd=1; entry 0 valid.
- Re-request 0x0040_1FFC su=0 -> tlbcode_do exactly 1 cycle after sampling, physical=0x1234_5FFC, walk_do stays 0. Same address with su=1 -> miss, walk issued.
- Fill ENTRIES+1 distinct pages -> the (ENTRIES+1)th fill overwrites entry 0; request to the first page misses again, the second page still hits.
- Request miss, walk_done with walk_fault=1 while request held -> tlbcode_fault pulses once, no tlbcode_do, no re-walk. Drop request -> IDLE; new request -> new walk.
- tlbflush asserted mid-walk, then walk_done ok -> no tlbcode_do, no fill. The held request re-walks and the second walk_done produces tlbcode_do.
- Request dropped during walk, walk_done ok -> no tlbcode_do, entry filled. Later request to the same page hits in 1 cycle. Assert rst mid-walk -> walk_do=0 immediately, state IDLE, all entries invalid.

Source files
------------

// File: rtl/tlbcode_responder.sv
// Code-TLB responder: small fully-associative cache of code-page translations
// in front of the shared page walker; hits answer in one cycle, misses walk and fill.
module tlbcode_responder #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlbcoderequest_do,
  input  logic [31:0] tlbcoderequest_address,
  input  logic        tlbcoderequest_su,
  output logic        tlbcode_do,
  output logic [31:0] tlbcode_linear,
  output logic [31:0] tlbcode_physical,
  output logic        tlbcode_cache_disable,
  output logic        tlbcode_fault,
  input  logic        tlbflush,
  output logic        walk_do,
  output logic [31:0] walk_address,
  output logic        walk_su,
  input  logic        walk_done,
  input  logic [31:0] walk_physical,
  input  logic        walk_cache_disable,
  input  logic        walk_fault
);

  localparam int PW = $clog2(ENTRIES);

  // state   | meaning
  // IDLE    | waiting for a request; lookup happens here
  // RESPOND | tlbcode_do strobe cycle
  // WALK    | walk_do held until walk_done
  // FAULT   | fault reported; wait for the initiator to drop its request
  typedef enum logic [1:0] {IDLE, RESPOND, WALK, FAULT} state_t;

  state_t state, state_nxt;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] ent_su;
  logic [ENTRIES-1:0] ent_cd;
  logic [19:0]        ent_tag  [ENTRIES];
  logic [19:0]        ent_phys [ENTRIES];
  logic [PW-1:0]      ptr;
  logic               flush_pending;

  logic          hit;
  logic [PW-1:0] hit_idx;

  logic load_hit, start_walk, fill, load_walk, set_fault;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && ent_tag[i] == tlbcoderequest_address[31:12] &&
          ent_su[i] == tlbcoderequest_su) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_hit   = 1'b0;
    start_walk = 1'b0;
    fill       = 1'b0;
    load_walk  = 1'b0;
    set_fault  = 1'b0;
    case (state)
      IDLE: begin
        if (tlbcoderequest_do && !tlbflush) begin
          if (hit) begin
            load_hit  = 1'b1;
            state_nxt = RESPOND;
          end else begin
            start_walk = 1'b1;
            state_nxt  = WALK;
          end
        end
      end
      RESPOND: state_nxt = IDLE;
      WALK: begin
        if (walk_done) begin
          // A flush during the walk makes its result stale: drop it and let
          // the held request miss and walk again.
          if (flush_pending || tlbflush) begin
            state_nxt = IDLE;
          end else if (walk_fault) begin
            set_fault = 1'b1;
            state_nxt = FAULT;
          end else begin
            fill = 1'b1;
            if (tlbcoderequest_do) begin
              load_walk = 1'b1;
              state_nxt = RESPOND;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      FAULT: if (!tlbcoderequest_do) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tlbcode_do = (state == RESPOND);
  assign walk_do    = (state == WALK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid                 <= '0;
      ptr                   <= '0;
      flush_pending         <= 1'b0;
      tlbcode_linear        <= '0;
      tlbcode_physical      <= '0;
      tlbcode_cache_disable <= 1'b0;
      tlbcode_fault         <= 1'b0;
      walk_address          <= '0;
      walk_su               <= 1'b0;
    end else begin
      tlbcode_fault <= set_fault;
      if (tlbflush)  valid      <= '0;
      else if (fill) valid[ptr] <= 1'b1;
      if (fill) ptr <= ptr + PW'(1);
      if (state == WALK) begin
        if (walk_done)     flush_pending <= 1'b0;
        else if (tlbflush) flush_pending <= 1'b1;
      end else begin
        flush_pending <= 1'b0;
      end
      if (load_hit) begin
        tlbcode_linear        <= tlbcoderequest_address;
        tlbcode_physical      <= {ent_phys[hit_idx], tlbcoderequest_address[11:0]};
        tlbcode_cache_disable <= ent_cd[hit_idx];
      end else if (load_walk) begin
        tlbcode_linear        <= walk_address;
        tlbcode_physical      <= {walk_physical[31:12], walk_address[11:0]};
        tlbcode_cache_disable <= walk_cache_disable;
      end
      if (start_walk) begin
        walk_address <= tlbcoderequest_address;
        walk_su      <= tlbcoderequest_su;
      end
    end
  end

  // Entry payload needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      ent_tag[ptr]  <= walk_address[31:12];
      ent_phys[ptr] <= walk_physical[31:12];
      ent_su[ptr]   <= walk_su;
      ent_cd[ptr]   <= walk_cache_disable;
    end
  end

endmodule

// File: tb/tb_tlbcode_responder.sv
// Self-checking bench for tlbcode_responder: scripted walker, response scoreboard.
module tb_tlbcode_responder;
  localparam int ENTRIES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tlbcoderequest_do = 1'b0;
  logic [31:0] tlbcoderequest_address = '0;
  logic        tlbcoderequest_su = 1'b0;
  logic        tlbcode_do;
  logic [31:0] tlbcode_linear;
  logic [31:0] tlbcode_physical;
  logic        tlbcode_cache_disable;
  logic        tlbcode_fault;
  logic        tlbflush = 1'b0;
  logic        walk_do;
  logic [31:0] walk_address;
  logic        walk_su;
  logic        walk_done = 1'b0;
  logic [31:0] walk_physical = '0;
  logic        walk_cache_disable = 1'b0;
  logic        walk_fault = 1'b0;

  tlbcode_responder #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .tlbcoderequest_do(tlbcoderequest_do),
    .tlbcoderequest_address(tlbcoderequest_address),
    .tlbcoderequest_su(tlbcoderequest_su),
    .tlbcode_do(tlbcode_do), .tlbcode_linear(tlbcode_linear),
    .tlbcode_physical(tlbcode_physical),
    .tlbcode_cache_disable(tlbcode_cache_disable),
    .tlbcode_fault(tlbcode_fault), .tlbflush(tlbflush),
    .walk_do(walk_do), .walk_address(walk_address), .walk_su(walk_su),
    .walk_done(walk_done), .walk_physical(walk_physical),
    .walk_cache_disable(walk_cache_disable), .walk_fault(walk_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] lin;
    logic [31:0] phys;
    logic        cd;
  } resp_t;

  resp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int resp_cnt = 0;
  int fault_cnt = 0;

  // Scoreboard: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (tlbcode_fault === 1'b1) fault_cnt++;
    if (tlbcode_do === 1'b1) begin
      resp_t e;
      resp_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp: got lin=%h phys=%h cd=%b, required no response",
                 tlbcode_linear, tlbcode_physical, tlbcode_cache_disable);
      end else begin
        e = exp_q.pop_front();
        if ({tlbcode_linear, tlbcode_physical, tlbcode_cache_disable} !== e) begin
          n_err++;
          $display("FAIL resp_fields: got lin=%h phys=%h cd=%b, required lin=%h phys=%h cd=%b",
                   tlbcode_linear, tlbcode_physical, tlbcode_cache_disable, e.lin, e.phys, e.cd);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] a, input logic s);
    tlbcoderequest_do      = 1'b1;
    tlbcoderequest_address = a;
    tlbcoderequest_su      = s;
  endtask

  task automatic drop_req();
    tlbcoderequest_do = 1'b0;
  endtask

  task automatic walk_finish(input logic [31:0] p, input logic cd, input logic f);
    walk_done          = 1'b1;
    walk_physical      = p;
    walk_cache_disable = cd;
    walk_fault         = f;
    tick();
    walk_done  = 1'b0;
    walk_fault = 1'b0;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] p, input logic cd);
    resp_t e;
    e.lin = l; e.phys = p; e.cd = cd;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    drop_req();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({tlbcode_do, walk_do, tlbcode_fault, tlbcode_linear, tlbcode_physical,
         tlbcode_cache_disable, walk_address, walk_su} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got do=%b walk_do=%b fault=%b lin=%h phys=%h, required all 0",
               tlbcode_do, walk_do, tlbcode_fault, tlbcode_linear, tlbcode_physical);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    start_req(32'h0040_1234, 1'b0);
    tick();
    n_cmp++;
    if ({walk_do, walk_address, walk_su} !== {1'b1, 32'h0040_1234, 1'b0}) begin
      n_err++;
      $display("FAIL cold_walk: got walk_do=%b addr=%h su=%b, required 1 00401234 0",
               walk_do, walk_address, walk_su);
    end
    push(32'h0040_1234, 32'h1234_5234, 1'b1);
    walk_finish(32'h1234_5ABC, 1'b1, 1'b0);
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b10) begin
      n_err++;
      $display("FAIL cold_resp: got do=%b walk_do=%b, required 1 0", tlbcode_do, walk_do);
    end
    drop_req();
    tick();
    n_cmp++;
    if (tlbcode_do !== 1'b0) begin
      n_err++;
      $display("FAIL resp_one_cycle: got do=%b, required 0", tlbcode_do);
    end
  endtask

  task automatic test_hit();
    push(32'h0040_1FFC, 32'h1234_5FFC, 1'b1);
    start_req(32'h0040_1FFC, 1'b0);
    tick();
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b10) begin
      n_err++;
      $display("FAIL hit_latency: got do=%b walk_do=%b, required 1 0", tlbcode_do, walk_do);
    end
    drop_req();
    tick();
    start_req(32'h0040_1FFC, 1'b1);
    tick();
    n_cmp++;
    if ({tlbcode_do, walk_do, walk_su} !== 3'b011) begin
      n_err++;
      $display("FAIL su_miss: got do=%b walk_do=%b walk_su=%b, required 0 1 1",
               tlbcode_do, walk_do, walk_su);
    end
    push(32'h0040_1FFC, 32'h0AAA_AFFC, 1'b0);
    walk_finish(32'h0AAA_A000, 1'b0, 1'b0);
    drop_req();
    tick();
  endtask

  task automatic test_flush_idle();
    start_req(32'h0040_1000, 1'b0);
    tlbflush = 1'b1;
    tick();
    tlbflush = 1'b0;
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_idle_suppress: got do=%b walk_do=%b, required 0 0", tlbcode_do, walk_do);
    end
    tick();
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_idle_miss: got do=%b walk_do=%b, required 0 1", tlbcode_do, walk_do);
    end
    push(32'h0040_1000, 32'h1234_5000, 1'b1);
    walk_finish(32'h1234_5000, 1'b1, 1'b0);
    drop_req();
    tick();
  endtask

  task automatic test_replacement();
    pulse_reset();
    for (int i = 0; i <= ENTRIES; i++) begin
      logic [31:0] a;
      a = {20'h10000 + 20'(i), 12'h010};
      start_req(a, 1'b0);
      tick();
      n_cmp++;
      if (walk_do !== 1'b1) begin
        n_err++;
        $display("FAIL fill_miss[%0d]: got walk_do=%b, required 1", i, walk_do);
      end
      push(a, {20'h50000 + 20'(i), 12'h010}, 1'b0);
      walk_finish({20'h50000 + 20'(i), 12'h000}, 1'b0, 1'b0);
      drop_req();
      tick();
    end
    push(32'h1000_1010, 32'h5000_1010, 1'b0);
    start_req(32'h1000_1010, 1'b0);
    tick();
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b10) begin
      n_err++;
      $display("FAIL second_page_hit: got do=%b walk_do=%b, required 1 0", tlbcode_do, walk_do);
    end
    drop_req();
    tick();
    start_req(32'h1000_0010, 1'b0);
    tick();
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b01) begin
      n_err++;
      $display("FAIL evicted_page_miss: got do=%b walk_do=%b, required 0 1", tlbcode_do, walk_do);
    end
    push(32'h1000_0010, 32'h5000_0010, 1'b0);
    walk_finish(32'h5000_0000, 1'b0, 1'b0);
    drop_req();
    tick();
  endtask

  task automatic test_fault();
    int f0, r0;
    start_req(32'h0070_0000, 1'b0);
    tick();
    f0 = fault_cnt;
    r0 = resp_cnt;
    walk_finish(32'h0, 1'b0, 1'b1);
    n_cmp++;
    if (tlbcode_fault !== 1'b1) begin
      n_err++;
      $display("FAIL fault_pulse: got fault=%b, required 1", tlbcode_fault);
    end
    repeat (5) tick();
    n_cmp++;
    if (fault_cnt != f0 + 1 || resp_cnt != r0 || walk_do !== 1'b0) begin
      n_err++;
      $display("FAIL fault_hold: got faults=%0d resps=%0d walk_do=%b, required %0d %0d 0",
               fault_cnt - f0, resp_cnt - r0, walk_do, 1, 0);
    end
    drop_req();
    tick(); tick();
    start_req(32'h0070_0000, 1'b0);
    tick();
    n_cmp++;
    if (walk_do !== 1'b1) begin
      n_err++;
      $display("FAIL fault_rewalk: got walk_do=%b, required 1", walk_do);
    end
    push(32'h0070_0000, 32'h0777_0000, 1'b0);
    walk_finish(32'h0777_0000, 1'b0, 1'b0);
    drop_req();
    tick();
  endtask

  task automatic test_flush_walk();
    start_req(32'h0080_0123, 1'b1);
    tick();
    tlbflush = 1'b1;
    tick();
    tlbflush = 1'b0;
    walk_finish(32'h0888_8000, 1'b1, 1'b0);
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_walk_drop: got do=%b walk_do=%b, required 0 0", tlbcode_do, walk_do);
    end
    tick();
    n_cmp++;
    if (walk_do !== 1'b1) begin
      n_err++;
      $display("FAIL flush_rewalk: got walk_do=%b, required 1", walk_do);
    end
    push(32'h0080_0123, 32'h0999_9123, 1'b1);
    walk_finish(32'h0999_9000, 1'b1, 1'b0);
    n_cmp++;
    if (tlbcode_do !== 1'b1) begin
      n_err++;
      $display("FAIL flush_second_resp: got do=%b, required 1", tlbcode_do);
    end
    drop_req();
    tick();
  endtask

  task automatic test_back_to_back();
    start_req(32'h0090_0456, 1'b0);
    tick();
    drop_req();
    tick();
    walk_finish(32'h3333_3000, 1'b0, 1'b0);
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b00) begin
      n_err++;
      $display("FAIL dropped_no_resp: got do=%b walk_do=%b, required 0 0", tlbcode_do, walk_do);
    end
    push(32'h0090_0ABC, 32'h3333_3ABC, 1'b0);
    start_req(32'h0090_0ABC, 1'b0);
    tick();
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b10) begin
      n_err++;
      $display("FAIL dropped_fill_hit: got do=%b walk_do=%b, required 1 0", tlbcode_do, walk_do);
    end
    drop_req();
    tick();
  endtask

  task automatic test_reset_mid_walk();
    start_req(32'h00A0_0000, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_walk_drop: got do=%b walk_do=%b, required 0 0", tlbcode_do, walk_do);
    end
    tick();
    rst = 1'b0;
    drop_req();
    tick();
    start_req(32'h0090_0ABC, 1'b0);
    tick();
    n_cmp++;
    if ({tlbcode_do, walk_do} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_invalidates: got do=%b walk_do=%b, required 0 1", tlbcode_do, walk_do);
    end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_flush_idle();
    test_replacement();
    test_fault();
    test_flush_walk();
    test_back_to_back();
    test_reset_mid_walk();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_resp: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
